// File: rtl/uart_ctrl_pkg.sv
// Shared types and default widths for the UART transmit controller.
// The FLUSH encoding is only reachable when UART_TX_CTRL_FLUSH_EN is defined.
package uart_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        FETCH   = 3'd2,
        START   = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5,
        GAP     = 3'd6,
        FLUSH   = 3'd7
    } ctrl_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// FIFO-side and transmitter-side handshake bundle for uart_tx_ctrl.
// The master modport is the controller's view.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = uart_ctrl_pkg::DEF_DATA_WIDTH
) ();

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  tx_busy;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (
        input  fifo_empty, fifo_data, tx_busy,
        output fifo_rd_en, tx_start, tx_data
    );

    modport slave (
        output fifo_empty, fifo_data, tx_busy,
        input  fifo_rd_en, tx_start, tx_data
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-frame gap timer: after a start pulse, done is high on the
// GAP_CYCLES-th following clock.
module uart_gap_timer import uart_ctrl_pkg::*; #(
    parameter int GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [W-1:0] LOAD = (GAP_CYCLES > 1) ? W'(GAP_CYCLES - 1) : '0;

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = LOAD;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// Moves bytes from a registered-read TX FIFO into a UART transmitter, one frame
// at a time. Optional FIFO flush port under macro UART_TX_CTRL_FLUSH_EN.
module uart_tx_ctrl import uart_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
`ifdef UART_TX_CTRL_FLUSH_EN
    input  logic                 flush,
`endif
    uart_tx_ctrl_if.master       bus,
    output logic                 ctrl_busy,
    output logic [CNT_WIDTH-1:0] sent_cnt
);

    ctrl_state_e           state_q, state_d;
    logic                  fifo_rd_en_q, fifo_rd_en_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0]  sent_cnt_q, sent_cnt_d;
    logic                  gap_start;
    logic                  gap_done;

    uart_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .start (gap_start),
        .done  (gap_done)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        sent_cnt_d = sent_cnt_q;
        gap_start  = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef UART_TX_CTRL_FLUSH_EN
                if (flush && !bus.fifo_empty) begin
                    state_d = FLUSH;
                end else
`endif
                if (enable && !bus.fifo_empty && !bus.tx_busy) begin
                    state_d = RD;
                end
            end
            RD: state_d = FETCH;
            FETCH: begin
                tx_data_d  = bus.fifo_data;
                sent_cnt_d = sent_cnt_q + 1'b1;
                state_d    = START;
            end
            START: state_d = WAIT_HI;
            WAIT_HI: begin
                if (bus.tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = GAP;
                        gap_start = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_done) state_d = IDLE;
            end
`ifdef UART_TX_CTRL_FLUSH_EN
            FLUSH: begin
                if (!flush || bus.fifo_empty) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Strobes are registered, so they are decoded from the next state.
        fifo_rd_en_d = (state_d == RD);
`ifdef UART_TX_CTRL_FLUSH_EN
        fifo_rd_en_d = fifo_rd_en_d || (state_d == FLUSH);
`endif
        tx_start_d = (state_d == START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fifo_rd_en_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            sent_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            sent_cnt_q   <= sent_cnt_d;
        end
    end

    assign bus.fifo_rd_en = fifo_rd_en_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign ctrl_busy      = (state_q != IDLE);
    assign sent_cnt       = sent_cnt_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a registered-read FIFO model and a
// fixed-length busy transmitter model; flush test under UART_TX_CTRL_FLUSH_EN.
module tb_uart_tx_ctrl;

    localparam int DW     = 8;
    localparam int CW     = 16;
    localparam int GAP    = 4;
    localparam int TX_LEN = 10;

    localparam int W_RD    = 0;
    localparam int W_START = 1;
    localparam int W_IDLE  = 2;
    localparam int W_BUSY  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
`ifdef UART_TX_CTRL_FLUSH_EN
    logic flush = 1'b0;
`endif
    logic          ctrl_busy;
    logic [CW-1:0] sent_cnt;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus_if ();

    uart_tx_ctrl #(
        .DATA_WIDTH (DW),
        .GAP_CYCLES (GAP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
`ifdef UART_TX_CTRL_FLUSH_EN
        .flush     (flush),
`endif
        .bus       (bus_if),
        .ctrl_busy (ctrl_busy),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: registered data one cycle after an accepted read, registered empty flag
    logic [DW-1:0] fmem[$];
    always @(posedge clk) begin
        if (bus_if.fifo_rd_en && !bus_if.fifo_empty && fmem.size() > 0)
            bus_if.fifo_data <= fmem.pop_front();
        bus_if.fifo_empty <= (fmem.size() == 0);
    end

    // Transmitter model: busy for TX_LEN cycles starting the cycle after tx_start
    int   tx_rem = 0;
    logic hold_busy = 1'b0;
    logic tx_mute = 1'b0;
    always @(posedge clk) begin
        if (bus_if.tx_start && !tx_mute) tx_rem <= TX_LEN;
        else if (tx_rem > 0)             tx_rem <= tx_rem - 1;
    end
    assign bus_if.tx_busy = (tx_rem != 0) || hold_busy;

    // Scoreboard and monitor
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int rd_total = 0;
    int start_total = 0;
    logic prev_busy = 1'b0;
    bit   gap_open = 1'b0;
    int   fall_cyc = 0;
    int   gap_hi = 0;
    int   gap_len_q[$];
    int   gap_hi_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            exp_cnt   = '0;
            prev_busy = 1'b0;
            gap_open  = 1'b0;
        end else begin
            if (bus_if.fifo_rd_en) begin
                rd_total++;
                if (gap_open) begin
                    gap_len_q.push_back(cyc - fall_cyc);
                    gap_hi_q.push_back(gap_hi);
                    gap_open = 1'b0;
                end
            end
            if (bus_if.tx_start) begin
                start_total++;
                exp_cnt = exp_cnt + 1'b1;
                check_eq("tx_start_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("tx_data", bus_if.tx_data, exp_q.pop_front());
                check_eq("sent_cnt", sent_cnt, exp_cnt);
            end
            if (prev_busy && !bus_if.tx_busy) begin
                fall_cyc = cyc;
                gap_open = 1'b1;
                gap_hi   = 0;
            end else if (gap_open && ctrl_busy) begin
                gap_hi++;
            end
            prev_busy = bus_if.tx_busy;
        end
    end

    task automatic push_byte(input logic [DW-1:0] b, input bit scored);
        fmem.push_back(b);
        if (scored) exp_q.push_back(b);
    endtask

    task automatic wait_for(input int sel, input int max_cyc, output int at_cyc);
        bit hit = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            case (sel)
                W_RD:    hit = bus_if.fifo_rd_en;
                W_START: hit = bus_if.tx_start;
                W_IDLE:  hit = !ctrl_busy;
                W_BUSY:  hit = bus_if.tx_busy;
                default: hit = 1'b1;
            endcase
            if (hit) at_cyc = cyc;
        end
        check_eq($sformatf("wait_sel%0d", sel), hit, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, bus_if.fifo_rd_en, 0);
        check_eq({tag, "_tx_start"}, bus_if.tx_start, 0);
        check_eq({tag, "_tx_data"}, bus_if.tx_data, 0);
        check_eq({tag, "_sent_cnt"}, sent_cnt, 0);
        check_eq({tag, "_ctrl_busy"}, ctrl_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, c, r0, s0;
        logic [CW-1:0] n0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Single frame latency
        @(negedge clk);
        p = cyc;
        push_byte(8'hA5, 1'b1);
        enable = 1'b1;
        wait_for(W_RD, 10, c);
        check_eq("a_rd_latency", c - p, 2);
        wait_for(W_START, 10, c);
        check_eq("a_start_latency", c - p, 4);
        check_eq("a_sent_cnt", sent_cnt, 1);
        wait_for(W_IDLE, 60, c);

        // Three frames with inter-frame gap
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gap_len_q.delete();
        gap_hi_q.delete();
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        for (int k = 0; k < 3; k++) wait_for(W_START, 60, c);
        wait_for(W_IDLE, 60, c);
        check_eq("b_gap_count", gap_len_q.size(), 2);
        foreach (gap_len_q[i]) begin
            check_eq($sformatf("b_fall_to_rd_%0d", i), gap_len_q[i], GAP + 2);
            check_eq($sformatf("b_gap_clocks_%0d", i), gap_hi_q[i], GAP);
        end
        check_eq("b_sent_cnt", sent_cnt, 3);

        // Enable dropped during WAIT_LO
        @(negedge clk);
        push_byte(8'h44, 1'b1);
        push_byte(8'h55, 1'b1);
        wait_for(W_START, 20, c);
        wait_for(W_BUSY, 10, c);
        @(negedge clk);
        enable = 1'b0;
        r0 = rd_total;
        repeat (40) @(negedge clk);
        check_eq("c_no_read_disabled", rd_total, r0);
        check_eq("c_idle_disabled", ctrl_busy, 0);
        enable = 1'b1;
        wait_for(W_RD, 10, c);
        wait_for(W_START, 10, c);
        wait_for(W_IDLE, 60, c);

        // Transmitter busy while idle
        @(negedge clk);
        hold_busy = 1'b1;
        push_byte(8'h66, 1'b1);
        r0 = rd_total;
        repeat (15) @(negedge clk);
        check_eq("d_no_read_busy", rd_total, r0);
        check_eq("d_idle_busy", ctrl_busy, 0);
        p = cyc;
        hold_busy = 1'b0;
        wait_for(W_RD, 10, c);
        check_eq("d_rd_after_busy", c - p, 1);
        wait_for(W_START, 10, c);
        wait_for(W_IDLE, 60, c);

        // Asynchronous reset in WAIT_HI
        @(negedge clk);
        tx_mute = 1'b1;
        push_byte(8'h77, 1'b1);
        wait_for(W_START, 10, c);
        repeat (3) @(negedge clk);
        check_eq("e_in_wait_hi", ctrl_busy, 1);
        #2 rst = 1'b0;
        #1 check_all_zero("e_async");
        s0 = start_total;
        push_byte(8'h88, 1'b1);
        tx_mute = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("e_no_start_in_reset", start_total, s0);
        p = cyc;
        rst = 1'b1;
        wait_for(W_RD, 10, c);
        check_eq("e_first_rd_after_release", c - p, 1);
        check_eq("e_no_start_before_rd", start_total, s0);
        wait_for(W_START, 10, c);
        wait_for(W_IDLE, 60, c);

`ifdef UART_TX_CTRL_FLUSH_EN
        begin
            int acc, first, last;
            acc = 0;
            first = -1;
            last = -1;
            @(negedge clk);
            enable = 1'b0;
            s0 = start_total;
            n0 = sent_cnt;
            for (int k = 0; k < 5; k++) push_byte(8'hC0 + 8'(k), 1'b0);
            repeat (2) @(negedge clk);
            flush = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus_if.fifo_rd_en && !bus_if.fifo_empty) begin
                    acc++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            flush = 1'b0;
            check_eq("f_reads", acc, 5);
            check_eq("f_consecutive", last - first, 4);
            check_eq("f_no_start", start_total, s0);
            check_eq("f_sent_cnt", sent_cnt, n0);
            check_eq("f_fifo_drained", fmem.size(), 0);
            check_eq("f_idle", ctrl_busy, 0);
            enable = 1'b1;
        end
`endif

        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
